// File: rtl/noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// NocOutputArbiter (module noc_output_arbiter)
//
// Wormhole round-robin arbiter for a single router output port. It sits
// between NUM_IN first-word-fall-through input FIFOs and one output FIFO.
// One input is granted per packet, and that grant is held from head to tail.
// One flit moves per cycle while the granted input has data and the output
// has room.
//
// Flit type lives in data[WIDTH-1:WIDTH-2]:
//   2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE
//
// Optional feature macro: NOC_ARB_STATS_EN
//   defined   : per-input saturating packet counters drive o_pkt_cnt
//   undefined : o_pkt_cnt is tied to zero and no counter flops exist
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   i_clear        synchronous clear, same effect as rst
//   i_empty        input FIFO empty flags, one per input
//   i_data         input FIFO head flits, input k at [k*WIDTH +: WIDTH]
//   o_pop          input FIFO pops (combinational, one-hot or zero)
//   i_almost_full  output FIFO almost-full (one slot of headroom left)
//   o_push         output FIFO push (registered)
//   o_data         output FIFO data (registered)
//   o_grant        current one-hot grant, zero when idle
//   o_busy         high while a packet is locked through
//   o_drop         one-cycle pulse after a stray non-head flit was discarded
//   o_pkt_cnt      packets completed per input, input k at [k*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module noc_output_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 34,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clear,
  input  logic [NUM_IN-1:0]           i_empty,
  input  logic [NUM_IN*WIDTH-1:0]     i_data,
  output logic [NUM_IN-1:0]           o_pop,
  input  logic                        i_almost_full,
  output logic                        o_push,
  output logic [WIDTH-1:0]            o_data,
  output logic [NUM_IN-1:0]           o_grant,
  output logic                        o_busy,
  output logic                        o_drop,
  output logic [NUM_IN*CNT_WIDTH-1:0] o_pkt_cnt
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NUM_IN-1:0]   grant_q;

  logic [NUM_IN-1:0]   req;
  logic [NUM_IN-1:0]   bad;
  logic [IDX_W-1:0]    bad_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [WIDTH-1:0]    g_flit;
  logic                g_last;
  logic                xfer;
  logic [NUM_IN-1:0]   pop_c;

  // The top type bit alone separates packet starters (HEAD, SINGLE) from
  // continuation flits (BODY, TAIL), so request/stray classification only
  // needs that bit of each input's head flit.
  always_comb begin
    req = '0;
    bad = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      req[k] = !i_empty[k] &&  i_data[k*WIDTH + WIDTH - 1];
      bad[k] = !i_empty[k] && !i_data[k*WIDTH + WIDTH - 1];
    end
  end

  // Lowest-index stray flit gets discarded first when idle.
  always_comb begin
    bad_idx = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (bad[k]) begin
        bad_idx = k[IDX_W-1:0];
      end
    end
  end

  // Round-robin search starting just after the last input that finished a
  // packet, wrapping around; the last-served input is considered last.
  always_comb begin
    int cand;
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_IN) begin
        cand = cand - NUM_IN;
      end
      if (!pick_found && req[cand]) begin
        pick_idx   = cand[IDX_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Granted input's head flit; bit WIDTH-2 set means TAIL or SINGLE, i.e.
  // this flit closes the packet.
  always_comb begin
    g_flit = i_data[int'(gnt_idx)*WIDTH +: WIDTH];
    g_last = g_flit[WIDTH-2];
  end

  // Almost-full already reserves one slot, so popping only when it is low
  // guarantees the registered push one cycle later always fits.
  assign xfer = (state == LOCKED) && !i_empty[gnt_idx] && !i_almost_full;

  // Pops are combinational so the FWFT head advances in the same cycle the
  // flit is captured into o_data. No pop happens in the arbitration cycle.
  always_comb begin
    pop_c = '0;
    if (state == IDLE) begin
      if (|bad) begin
        pop_c[bad_idx] = 1'b1;
      end
    end else if (xfer) begin
      pop_c = grant_q;
    end
  end

  // Pop is forced low while reset is asserted; clear does not gate it, so a
  // flit popped in the clear cycle is deliberately lost.
  assign o_pop = rst ? '0 : pop_c;

  // Main arbiter state machine. Clear behaves exactly like reset, but
  // synchronously. Push and drop are single-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_IN - 1);
      gnt_idx <= '0;
      grant_q <= '0;
      o_push  <= 1'b0;
      o_data  <= '0;
      o_drop  <= 1'b0;
    end else if (i_clear) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_IN - 1);
      gnt_idx <= '0;
      grant_q <= '0;
      o_push  <= 1'b0;
      o_data  <= '0;
      o_drop  <= 1'b0;
    end else begin
      o_push <= 1'b0;
      o_drop <= 1'b0;
      case (state)
        IDLE: begin
          // Stray continuation flits are flushed before any new grant.
          if (|bad) begin
            o_drop <= 1'b1;
          end else if (pick_found) begin
            grant_q <= NUM_IN'(1) << pick_idx;
            gnt_idx <= pick_idx;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          // Grant is held while the input is empty: wormhole, no timeout.
          if (xfer) begin
            o_push <= 1'b1;
            o_data <= g_flit;
            if (g_last) begin
              state   <= IDLE;
              grant_q <= '0;
              ptr     <= gnt_idx;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state == LOCKED);

`ifdef NOC_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_cnt [NUM_IN];

  // One count per completed packet (TAIL or SINGLE transferred), sticking
  // at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_IN; k++) begin
        pkt_cnt[k] <= '0;
      end
    end else if (i_clear) begin
      for (int k = 0; k < NUM_IN; k++) begin
        pkt_cnt[k] <= '0;
      end
    end else if (xfer && g_last && (pkt_cnt[gnt_idx] != {CNT_WIDTH{1'b1}})) begin
      pkt_cnt[gnt_idx] <= pkt_cnt[gnt_idx] + 1'b1;
    end
  end

  always_comb begin
    o_pkt_cnt = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      o_pkt_cnt[k*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[k];
    end
  end
`else
  assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for noc_output_arbiter (NUM_IN=4, WIDTH=34, CNT_WIDTH=16).
// Input FIFOs are modelled as queues that react to o_pop. Each flit carries
// its source input and a sequence number. Expected output flits are queued
// in predicted arbitration order when stimulus is loaded, and are compared
// as the DUT pushes. Per-cycle checks cover grant timing, backpressure,
// stray-flit drops, clear and the optional counters (NOC_ARB_STATS_EN).
// ---------------------------------------------------------------------------
module tb_noc_output_arbiter;

  localparam int NUM_IN    = 4;
  localparam int WIDTH     = 34;
  localparam int CNT_WIDTH = 16;

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic                        clk;
  logic                        rst;
  logic                        i_clear;
  logic [NUM_IN-1:0]           i_empty;
  logic [NUM_IN*WIDTH-1:0]     i_data;
  logic [NUM_IN-1:0]           o_pop;
  logic                        i_almost_full;
  logic                        o_push;
  logic [WIDTH-1:0]            o_data;
  logic [NUM_IN-1:0]           o_grant;
  logic                        o_busy;
  logic                        o_drop;
  logic [NUM_IN*CNT_WIDTH-1:0] o_pkt_cnt;

  logic [WIDTH-1:0] inq [NUM_IN][$];
  logic [WIDTH-1:0] expq [$];
  logic [NUM_IN-1:0] pop_snap;
  int n_total;
  int n_bad;
  int drops;

  noc_output_arbiter #(
    .NUM_IN   (NUM_IN),
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (i_clear),
    .i_empty      (i_empty),
    .i_data       (i_data),
    .o_pop        (o_pop),
    .i_almost_full(i_almost_full),
    .o_push       (o_push),
    .o_data       (o_data),
    .o_grant      (o_grant),
    .o_busy       (o_busy),
    .o_drop       (o_drop),
    .o_pkt_cnt    (o_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [1:0] t, input int src, input int seq);
    return {t, 16'(src), 16'(seq)};
  endfunction

  // Put a flit into input k's FIFO; optionally predict it at the output.
  task automatic load(input int k, input logic [1:0] t, input int seq, input bit expect_out);
    logic [WIDTH-1:0] f;
    f = mk(t, k, seq);
    inq[k].push_back(f);
    if (expect_out) expq.push_back(f);
  endtask

  task automatic driveInputs();
    for (int k = 0; k < NUM_IN; k++) begin
      i_empty[k] = (inq[k].size() == 0);
      i_data[k*WIDTH +: WIDTH] = (inq[k].size() == 0) ? '0 : inq[k][0];
    end
  endtask

  // One clock cycle: drive FIFO heads at the falling edge, snapshot pops,
  // then after the rising edge retire popped flits and score any push.
  task automatic applyStimulus();
    logic [WIDTH-1:0] e;
    driveInputs();
    #1;
    pop_snap = o_pop;
    if ($countones(pop_snap) > 1) checkOutput("pop_onehot", 64'(pop_snap), 64'(0));
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (pop_snap[k]) begin
        if (inq[k].size() == 0) checkOutput("pop_empty", 64'(k), 64'(NUM_IN));
        else void'(inq[k].pop_front());
      end
    end
    if (o_push) begin
      if (expq.size() == 0) begin
        checkOutput("unexp_push", 64'(o_data), 64'(0));
      end else begin
        e = expq.pop_front();
        checkOutput("push_data", 64'(o_data), 64'(e));
      end
    end
    if (o_drop) drops++;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while ((expq.size() != 0) && (c < max_cycles)) begin
      applyStimulus();
      c++;
    end
    checkOutput("drain_left", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    drops         = 0;
    pop_snap      = '0;
    rst           = 1'b1;
    i_clear       = 1'b0;
    i_almost_full = 1'b0;
    driveInputs();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_push",  64'(o_push),  64'(0));
    checkOutput("rst_grant", 64'(o_grant), 64'(0));
    checkOutput("rst_busy",  64'(o_busy),  64'(0));
    checkOutput("rst_data",  64'(o_data),  64'(0));
    checkOutput("rst_pop",   64'(o_pop),   64'(0));
    rst = 1'b0;

    // Idle with all inputs empty.
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("idle_pop",   64'(pop_snap), 64'(0));
      checkOutput("idle_push",  64'(o_push),   64'(0));
      checkOutput("idle_grant", 64'(o_grant),  64'(0));
      checkOutput("idle_busy",  64'(o_busy),   64'(0));
    end

    // Single 3-flit packet on input 2: grant N+1, pushes N+2..N+4.
    load(2, T_HEAD, 0, 1);
    load(2, T_BODY, 1, 1);
    load(2, T_TAIL, 2, 1);
    applyStimulus();
    checkOutput("p2_arb_pop", 64'(pop_snap), 64'(0));
    checkOutput("p2_grant",   64'(o_grant),  64'(4'b0100));
    checkOutput("p2_busy",    64'(o_busy),   64'(1));
    checkOutput("p2_nopush",  64'(o_push),   64'(0));
    applyStimulus();
    checkOutput("p2_push1",   64'(o_push),   64'(1));
    applyStimulus();
    checkOutput("p2_push2",   64'(o_push),   64'(1));
    checkOutput("p2_hold",    64'(o_grant),  64'(4'b0100));
    applyStimulus();
    checkOutput("p2_push3",   64'(o_push),   64'(1));
    checkOutput("p2_release", 64'(o_grant),  64'(0));
    checkOutput("p2_idle",    64'(o_busy),   64'(0));
    checkOutput("p2_sb",      64'(expq.size()), 64'(0));

    // Pointer now at 2: input 3 must win over input 1.
    load(3, T_SINGLE, 0, 1);
    load(1, T_SINGLE, 0, 1);
    applyStimulus();
    checkOutput("ptr_grant3", 64'(o_grant), 64'(4'b1000));
    drain(20);

    // Backpressure mid-packet on input 1 while input 3 waits.
    for (int s = 0; s < 5; s++) load(1, (s == 0) ? T_HEAD : ((s == 4) ? T_TAIL : T_BODY), 10 + s, 1);
    applyStimulus();
    checkOutput("bp_grant", 64'(o_grant), 64'(4'b0010));
    applyStimulus();
    checkOutput("bp_head_push", 64'(o_push), 64'(1));
    i_almost_full = 1'b1;
    load(3, T_HEAD, 20, 1);
    load(3, T_TAIL, 21, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("bp_pop",   64'(pop_snap), 64'(0));
      checkOutput("bp_push",  64'(o_push),   64'(0));
      checkOutput("bp_grant_hold", 64'(o_grant), 64'(4'b0010));
    end
    i_almost_full = 1'b0;
    applyStimulus();
    checkOutput("bp_resume_pop",  64'(pop_snap), 64'(4'b0010));
    checkOutput("bp_resume_push", 64'(o_push),   64'(1));
    drain(40);

    // Wormhole hold while the granted input runs dry.
    load(0, T_HEAD, 30, 1);
    applyStimulus();
    checkOutput("wh_grant", 64'(o_grant), 64'(4'b0001));
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("wh_hold",   64'(o_grant), 64'(4'b0001));
      checkOutput("wh_nopush", 64'(o_push),  64'(0));
    end
    load(0, T_TAIL, 31, 1);
    load(2, T_SINGLE, 32, 1);
    drain(20);

    // Stray BODY flit while idle is dropped, never granted.
    drops = 0;
    load(0, T_BODY, 40, 0);
    applyStimulus();
    checkOutput("drop_pop",   64'(pop_snap), 64'(4'b0001));
    checkOutput("drop_pulse", 64'(o_drop),   64'(1));
    checkOutput("drop_grant", 64'(o_grant),  64'(0));
    applyStimulus();
    checkOutput("drop_once",  64'(o_drop),   64'(0));
    checkOutput("drop_nogrant", 64'(o_grant), 64'(0));
    checkOutput("drop_pop2",  64'(pop_snap), 64'(0));

    // Clear during a transfer: flit popped and lost, rest become strays.
    load(2, T_HEAD, 50, 0);
    load(2, T_BODY, 51, 0);
    load(2, T_TAIL, 52, 0);
    applyStimulus();
    checkOutput("clr_grant", 64'(o_grant), 64'(4'b0100));
    i_clear = 1'b1;
    applyStimulus();
    i_clear = 1'b0;
    checkOutput("clr_pop",   64'(pop_snap), 64'(4'b0100));
    checkOutput("clr_push",  64'(o_push),   64'(0));
    checkOutput("clr_grant0", 64'(o_grant), 64'(0));
    checkOutput("clr_busy",  64'(o_busy),   64'(0));
    drops = 0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("clr_drops", 64'(drops), 64'(2));
    checkOutput("clr_empty", 64'(inq[2].size()), 64'(0));

    // All inputs full of SINGLEs: grants 0,1,2,3,... two cycles apart.
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NUM_IN; k++) load(k, T_SINGLE, 60 + r, 1);
    for (int s = 0; s < 24; s++) begin
      applyStimulus();
      if (s % 2 == 0) checkOutput("rr_grant", 64'(o_grant), 64'(1) << ((s / 2) % NUM_IN));
      else            checkOutput("rr_gap",   64'(o_grant), 64'(0));
    end
    checkOutput("rr_sb", 64'(expq.size()), 64'(0));

`ifdef NOC_ARB_STATS_EN
    i_clear = 1'b1;
    applyStimulus();
    i_clear = 1'b0;
    checkOutput("cnt_clear0", 64'(o_pkt_cnt), 64'(0));
    for (int p = 0; p < 3; p++) begin
      load(1, T_HEAD, 70 + 2*p, 1);
      load(1, T_TAIL, 71 + 2*p, 1);
    end
    drain(40);
    checkOutput("cnt_in1", 64'(o_pkt_cnt), 64'(3) << CNT_WIDTH);
    i_clear = 1'b1;
    applyStimulus();
    i_clear = 1'b0;
    checkOutput("cnt_clear", 64'(o_pkt_cnt), 64'(0));
`else
    checkOutput("cnt_tied0", 64'(o_pkt_cnt), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
